mont_sq_sequencer: RTL and testbench

// - Sequences one shared multi-mode multiplier through repeated Montgomery squarings x <- x^2*R^-1 mod N.
// - Each iteration is three passes: SQ (square), LO (low product times N'), HI (high product times N, plus add term).
// - Sits between the VDF top-level (start/iteration count/result) and the multiplier datapath.
// - Owns all operand muxing, intermediate storage and the iteration counter.

---
 rtl/mont_sq_sequencer.sv | 128 ++++++++++++
 tb/tb_mont_sq_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_sq_sequencer.sv
// mont_sq_sequencer: runs T Montgomery squarings (SQ, LO, HI passes) through one shared multiplier.
// Define MONT_SEQ_STATS_EN to add the busy-cycle counter and the sticky stray-response flag.
module mont_sq_sequencer #(
  parameter int NUM_ELEMENTS = 33,
  parameter int DSP_BIT_LEN = 17,
  parameter int ITER_W = 32
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_n,
  input  logic                                    i_start,
  input  logic                                    i_abort,
  input  logic [ITER_W-1:0]                       i_iter,
  input  logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]     i_x,
  input  logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]     i_mod,
  input  logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]     i_mod_inv,
  output logic                                    o_busy,
  output logic                                    o_done,
  output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]     o_result,
  output logic                                    o_mul_val,
  output logic [1:0]                              o_mul_ctl,
  output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]     o_mul_dat_a,
  output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]     o_mul_dat_b,
  output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]     o_mul_add_term,
  input  logic                                    i_mul_val,
  input  logic [2*NUM_ELEMENTS*DSP_BIT_LEN-1:0]   i_mul_dat
`ifdef MONT_SEQ_STATS_EN
  ,
  output logic [31:0]                             o_cyc_cnt,
  output logic                                    o_proto_err
`endif
);
  localparam int W = NUM_ELEMENTS * DSP_BIT_LEN;
  localparam logic [3:0] S_IDLE = 4'd0, S_SQ_ISS = 4'd1, S_SQ_WT = 4'd2, S_LO_ISS = 4'd3,
                         S_LO_WT = 4'd4, S_HI_ISS = 4'd5, S_HI_WT = 4'd6, S_DONE = 4'd7,
                         S_DRAIN = 4'd8;
  localparam logic [1:0] C_LO = 2'd0, C_HI = 2'd1, C_SQ = 2'd2;

  logic [3:0]        r_state, w_next;
  logic [1:0]        r_ctl;
  logic [W-1:0]      r_x, r_l, r_h, r_q, r_result;
  logic [ITER_W-1:0] r_cnt;
  logic              r_done;
  logic              w_wt, w_iss, w_rsp, w_acc;

  assign w_wt  = r_state inside {S_SQ_WT, S_LO_WT, S_HI_WT};
  assign w_iss = r_state inside {S_SQ_ISS, S_LO_ISS, S_HI_ISS};
  assign w_rsp = w_wt & i_mul_val & ~i_abort;
  assign w_acc = (r_state == S_IDLE) & i_start;

  // ISS states fall through to their WT state; SQ_WT/LO_WT advance to the next ISS
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:                       w_next = !i_start ? S_IDLE : (i_iter == '0) ? S_DONE : S_SQ_ISS;
      S_SQ_ISS, S_LO_ISS, S_HI_ISS: w_next = i_abort ? S_DRAIN : r_state + 4'd1;
      S_SQ_WT, S_LO_WT, S_HI_WT:    w_next = i_abort ? (i_mul_val ? S_IDLE : S_DRAIN) :
                                             !i_mul_val ? r_state :
                                             (r_state != S_HI_WT) ? r_state + 4'd1 :
                                             (r_cnt <= ITER_W'(1)) ? S_DONE : S_SQ_ISS;
      S_DONE:                       w_next = S_IDLE;
      S_DRAIN:                      w_next = i_mul_val ? S_IDLE : S_DRAIN;
      default:                      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_ctl    <= C_SQ;
      r_x      <= '0;
      r_l      <= '0;
      r_h      <= '0;
      r_q      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == S_DONE;
      r_ctl   <= w_next == S_SQ_ISS ? C_SQ : w_next == S_LO_ISS ? C_LO : w_next == S_HI_ISS ? C_HI : r_ctl;
      if (r_state == S_DONE) r_result <= r_x;
      if (w_acc) begin
        r_x   <= i_x;
        r_cnt <= i_iter;
      end
      if (w_rsp && r_state == S_SQ_WT) begin
        r_l <= i_mul_dat[W-1:0];
        r_h <= i_mul_dat[2*W-1:W];
      end
      if (w_rsp && r_state == S_LO_WT) r_q <= i_mul_dat[W-1:0];
      if (w_rsp && r_state == S_HI_WT) begin
        r_x   <= i_mul_dat[2*W-1:W];
        r_cnt <= r_cnt - ITER_W'(r_cnt != '0);
      end
    end
  end

  // operands follow the last issued pass so they hold through the wait and any drain
  assign o_busy         = (r_state != S_IDLE) | r_done;
  assign o_done         = r_done;
  assign o_result       = r_result;
  assign o_mul_val      = w_iss;
  assign o_mul_ctl      = r_ctl;
  assign o_mul_dat_a    = r_ctl == C_LO ? r_l : r_ctl == C_HI ? r_q : r_x;
  assign o_mul_dat_b    = r_ctl == C_LO ? i_mod_inv : r_ctl == C_HI ? i_mod : r_x;
  assign o_mul_add_term = r_ctl == C_HI ? r_h : '0;

`ifdef MONT_SEQ_STATS_EN
  logic [31:0] r_cyc_cnt;
  logic        r_proto_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cyc_cnt   <= '0;
      r_proto_err <= 1'b0;
    end else if (w_acc) begin
      r_cyc_cnt   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (r_state != S_IDLE && r_cyc_cnt != '1) r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (i_mul_val && !w_wt && r_state != S_DRAIN) r_proto_err <= 1'b1;
    end
  end

  assign o_cyc_cnt   = r_cyc_cnt;
  assign o_proto_err = r_proto_err;
`endif
endmodule

// File: tb/tb_mont_sq_sequencer.sv
// tb_mont_sq_sequencer: vector table plus abort/reset/stray sequences against a 3-cycle behavioural multiplier.
module tb_mont_sq_sequencer;
  localparam int NE = 4, DL = 17, W = NE * DL, W2 = 2 * W;
  localparam logic [W-1:0] BIG_N = 68'h1_2345_6789_ABCD_EF01;
  localparam logic [W-1:0] SML_N = 68'd1000003;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort_i = 1'b0;
  logic [31:0] iter = '0;
  logic [W-1:0] x_i = '0, mod_i = '0, inv_i = '0;
  logic busy, done, mul_val, mul_val_in;
  logic mdl_mv = 1'b0, stray_mv = 1'b0;
  logic [1:0] ctl, mdl_cnt = '0;
  logic [W-1:0] result, dat_a, dat_b, add_t;
  logic [W2-1:0] mdl_dat = '0;
`ifdef MONT_SEQ_STATS_EN
  logic [31:0] cyc_cnt;
  logic proto_err;
`endif
  int n_chk = 0, n_pass = 0;

  typedef struct {
    int t;
    logic [W-1:0] x;
    logic [W-1:0] n;
    int pulses;
    int lat;
  } vec_t;
  vec_t vt[5];

  assign mul_val_in = mdl_mv | stray_mv;

  mont_sq_sequencer #(.NUM_ELEMENTS(NE), .DSP_BIT_LEN(DL), .ITER_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort_i), .i_iter(iter),
    .i_x(x_i), .i_mod(mod_i), .i_mod_inv(inv_i), .o_busy(busy), .o_done(done),
    .o_result(result), .o_mul_val(mul_val), .o_mul_ctl(ctl), .o_mul_dat_a(dat_a),
    .o_mul_dat_b(dat_b), .o_mul_add_term(add_t), .i_mul_val(mul_val_in), .i_mul_dat(mdl_dat)
`ifdef MONT_SEQ_STATS_EN
    , .o_cyc_cnt(cyc_cnt), .o_proto_err(proto_err)
`endif
  );

  always #5 clk = ~clk;

  // HI carry: the discarded low product L equals R - low(Q*N) whenever nonzero
  function automatic logic [W2-1:0] mul_model(input logic [1:0] c, input logic [W-1:0] a, b, ad);
    logic [W2-1:0] p, r;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    r = '0;
    r[W] = 1'b1;
    if (c == 2'd1) p = p + {ad, {W{1'b0}}} + ((p[W-1:0] != '0) ? r : '0);
    return p;
  endfunction

  always @(posedge clk) begin
    mdl_mv <= 1'b0;
    if (mdl_cnt != 2'd0) begin
      mdl_cnt <= mdl_cnt - 2'd1;
      if (mdl_cnt == 2'd1) mdl_mv <= 1'b1;
    end
    if (mul_val) begin
      mdl_cnt <= 2'd2;
      mdl_dat <= mul_model(ctl, dat_a, dat_b, add_t);
    end
  end

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, b, n);
    logic [W2-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(p % {{W{1'b0}}, n});
  endfunction

  function automatic logic [W-1:0] n_inv(input logic [W-1:0] n);
    logic [W-1:0] v;
    v = n;
    for (int i = 0; i < 7; i++) v = v * (W'(2) - n * v);
    return -v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W2-1:0] act, input logic [W2-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // x_t * R^(2^t-1) == x^(2^t) (mod N), with R mod N taken as (2^W - N) mod N
  task automatic chk_res(input string nm, input logic [W-1:0] res, x, n, input int t);
    logic [W-1:0] lhs, rhs, rm;
    if (t == 0) chk(nm, W2'(res), W2'(x));
    else begin
      rm = (-n) % n;
      lhs = res % n;
      for (int i = 0; i < (1 << t) - 1; i++) lhs = mulmod(lhs, rm, n);
      rhs = x % n;
      for (int i = 0; i < t; i++) rhs = mulmod(rhs, rhs, n);
      chk(nm, W2'(lhs), W2'(rhs));
    end
  endtask

  task automatic start_job(input int t, input logic [W-1:0] x, n);
    iter = t;
    x_i = x;
    mod_i = n;
    inv_i = n_inv(n);
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int lat, output logic [W-1:0] res,
                           output int pulses, output bit order_ok);
    logic [1:0] ord [3];
    ord = '{2'd2, 2'd0, 2'd1};
    lat = -1;
    pulses = 0;
    order_ok = 1'b1;
    res = '0;
    for (int c = c0; c < 400; c++) begin
      if (mul_val) begin
        if (ctl != ord[pulses % 3]) order_ok = 1'b0;
        pulses++;
      end
      if (done) begin
        lat = c;
        res = result;
        break;
      end
      tick;
    end
  endtask

  task automatic run_check(input string nm, input int t, input logic [W-1:0] x, n,
                           input int exp_p, input int exp_lat);
    int lat, pulses;
    bit ok;
    logic [W-1:0] res;
    start_job(t, x, n);
    wait_done(1, lat, res, pulses, ok);
    chk({nm, "_latency"}, W2'(lat), W2'(exp_lat));
    chk({nm, "_pulses"}, W2'(pulses), W2'(exp_p));
    chk({nm, "_ctl_order"}, W2'(ok), W2'(1));
    chk_res({nm, "_result"}, res, x, n, t);
    chk({nm, "_busy_at_done"}, W2'(busy), W2'(1));
    tick;
    chk({nm, "_busy_after"}, W2'(busy), W2'(0));
  endtask

  initial begin
    int lat, pulses;
    bit ok, seen, arrived;
    logic [W-1:0] res;
    vt[0] = '{0, {17'd4, 17'd3, 17'd2, 17'd1}, BIG_N, 0, 2};
    vt[1] = '{1, 68'd12345, SML_N, 3, 14};
    vt[2] = '{5, 68'h0_ABCD_1234_5678_9ABC, BIG_N, 15, 62};
    vt[3] = '{2, 68'h1_0000_0000_0000_0001, BIG_N, 6, 26};
    vt[4] = '{0, {W{1'b1}}, BIG_N, 0, 2};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", W2'(busy), W2'(0));
    chk("rst_done", W2'(done), W2'(0));
    chk("rst_mul_val", W2'(mul_val), W2'(0));
    chk("rst_ctl", W2'(ctl), W2'(2));
    chk("rst_result", W2'(result), W2'(0));
    chk("rst_dat_a", W2'(dat_a), W2'(0));
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 5; i++) run_check($sformatf("v%0d", i), vt[i].t, vt[i].x, vt[i].n, vt[i].pulses, vt[i].lat);

    // abort while the LO pass is outstanding (LO issued in cycle 5, answered in cycle 8)
    start_job(3, vt[2].x, BIG_N);
    repeat (5) tick;
    chk("abort_ctl_lo", W2'(ctl), W2'(0));
    abort_i = 1'b1;
    tick;
    abort_i = 1'b0;
    chk("abort_busy_drain", W2'(busy), W2'(1));
    tick;
    chk("abort_rsp_seen", W2'(mul_val_in), W2'(1));
    chk("abort_busy_rsp", W2'(busy), W2'(1));
    tick;
    chk("abort_busy_drop", W2'(busy), W2'(0));
    seen = 1'b0;
    repeat (10) begin
      seen |= done | mul_val | busy;
      tick;
    end
    chk("abort_quiet", W2'(seen), W2'(0));
    run_check("post_abort", 1, 68'd777, SML_N, 3, 14);

    // second start while busy must not disturb the running job
    start_job(1, 68'd12345, SML_N);
    tick;
    tick;
    iter = 7;
    x_i = 68'd999;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(4, lat, res, pulses, ok);
    chk("busy_start_latency", W2'(lat), W2'(14));
    chk_res("busy_start_result", res, 68'd12345, SML_N, 1);
    repeat (2) tick;
    stray_mv = 1'b1;
    tick;
    stray_mv = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      seen |= done | mul_val | busy;
      tick;
    end
    chk("stray_ignored", W2'(seen), W2'(0));
`ifdef MONT_SEQ_STATS_EN
    chk("stray_proto_err", W2'(proto_err), W2'(1));
    chk("cyc_cnt_last_job", W2'(cyc_cnt), W2'(13));
`endif

    // asynchronous reset in HI_WT (HI issued in cycle 9, answer due in cycle 12)
    start_job(2, vt[3].x, BIG_N);
    repeat (9) tick;
    chk("rst_mid_ctl_hi", W2'(ctl), W2'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", W2'(busy), W2'(0));
    chk("arst_mul_val", W2'(mul_val), W2'(0));
    chk("arst_ctl", W2'(ctl), W2'(2));
    chk("arst_result", W2'(result), W2'(0));
    chk("arst_add_term", W2'(add_t), W2'(0));
    #1 rst_n = 1'b1;
    seen = 1'b0;
    arrived = 1'b0;
    repeat (10) begin
      tick;
      seen |= done | mul_val | busy;
      arrived |= mul_val_in;
    end
    chk("late_rsp_arrived", W2'(arrived), W2'(1));
    chk("late_rsp_ignored", W2'(seen), W2'(0));
    run_check("post_reset", 1, 68'd31337, SML_N, 3, 14);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
